// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_pkg                                                   |
// | Purpose : Shared UART constants: parity encodings, one-hot receive   |
// |           state codes, bit timing and the parity-bit helper.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Par control encodings, identical on the transmit and receive side
  localparam logic [1:0] pPar_Odd   = 2'd0;
  localparam logic [1:0] pPar_Even  = 2'd1;
  localparam logic [1:0] pPar_Space = 2'd2;
  localparam logic [1:0] pPar_Mark  = 2'd3;

  // One-hot receive state codes; bit order matches the state flag ports
  localparam logic [4:0] pIdle   = 5'b00001;
  localparam logic [4:0] pStart  = 5'b00010;
  localparam logic [4:0] pShift  = 5'b00100;
  localparam logic [4:0] pParity = 5'b01000;
  localparam logic [4:0] pStop   = 5'b10000;

  // CE_16x ticks per serial bit
  localparam int unsigned pTicksPerBit = 16;

  typedef enum logic [4:0] {
    RX_IDLE   = pIdle,
    RX_START  = pStart,
    RX_SHIFT  = pShift,
    RX_PARITY = pParity,
    RX_STOP   = pStop
  } rx_state_e;

  // Parity bit a transmitter places after the data bits
  function automatic logic par_bit(input logic [7:0] data, input logic [1:0] par);
    logic p;
    case (par)
      pPar_Odd:   p = ~(^data);
      pPar_Even:  p = ^data;
      pPar_Space: p = 1'b0;
      default:    p = 1'b1;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rxd_vote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rxd_vote                                              |
// | Purpose : RxD 2-flop synchronizer plus 3-sample majority vote.       |
// |           RxD_Vote is the majority of the current synchronized       |
// |           sample and the two before it.                              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_rxd_vote (
  input  logic Clk,
  input  logic Rst,
  input  logic CE_16x,
  input  logic RxD,
  output logic RxD_Sync,
  output logic RxD_Vote
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q,  hist_d;

  // Advance the synchronizer and sample history on each 16x tick only
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    hist_d  = hist_q;
    if (CE_16x) begin
      sync1_d = RxD;
      sync2_d = sync1_q;
      hist_d  = {hist_q[0], sync2_q};
    end
  end

  // Line idles high, so every stage resets to 1
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign RxD_Sync = sync2_q;
  assign RxD_Vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);

endmodule
`default_nettype wire

// File: rtl/uart_rxsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rxsm                                                  |
// | Purpose : UART receive state machine. Frames start/data/parity/stop  |
// |           at 16x oversampling, checks parity/framing, detects break  |
// |           and writes each character to the receive FIFO.             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_rxsm
  import uart_pkg::*;
#(
  parameter logic [3:0] pSampleTick = 4'd8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CE_16x,
  input  logic       Len,
  input  logic       NumStop,
  input  logic       ParEn,
  input  logic [1:0] Par,
  input  logic       RxD,
  output logic [7:0] RHR,
  output logic       RF_WE,
  output logic       PE,
  output logic       FE,
  output logic       Brk,
  output logic       RxIdle,
  output logic       RxStart,
  output logic       RxShift,
  output logic       RxParity,
  output logic       RxStop
);

  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       stop2_q, stop2_d;    // first of two stop bits already voted
  logic       brkw_q, brkw_d;      // break reported, waiting for line high
  logic [7:0] data_q, data_d;
  logic       pbit_q, pbit_d;      // received parity bit
  logic       fe_acc_q, fe_acc_d;  // a 0 seen on an earlier stop bit
  logic       len_q, len_d;
  logic       nstop_q, nstop_d;
  logic       paren_q, paren_d;
  logic [1:0] par_q, par_d;
  logic [7:0] rhr_q, rhr_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       brk_q, brk_d;
  logic       rf_we;

  logic w_sync, w_vote, w_sample, w_last_bit, w_fe_now, w_brk_now;

  uart_rxd_vote u_vote (
    .Clk      (Clk),
    .Rst      (Rst),
    .CE_16x   (CE_16x),
    .RxD      (RxD),
    .RxD_Sync (w_sync),
    .RxD_Vote (w_vote)
  );

  assign w_sample   = CE_16x && (tick_q == pSampleTick + 4'd1);
  assign w_last_bit = (bit_q == (len_q ? 3'd6 : 3'd7));
  assign w_fe_now   = fe_acc_q | ~w_vote;
  assign w_brk_now  = w_fe_now && (data_q == 8'h00) && (!paren_q || !pbit_q);

  // Next-state logic; nothing advances without a 16x tick or during reset
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    stop2_d  = stop2_q;
    brkw_d   = brkw_q;
    data_d   = data_q;
    pbit_d   = pbit_q;
    fe_acc_d = fe_acc_q;
    len_d    = len_q;
    nstop_d  = nstop_q;
    paren_d  = paren_q;
    par_d    = par_q;
    rhr_d    = rhr_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    brk_d    = brk_q;
    rf_we    = 1'b0;
    if (CE_16x && !Rst) begin
      // Tick counter free-runs (wrapping at 16) while a frame is in progress
      if (state_q != RX_IDLE && !brkw_q) begin
        tick_d = tick_q + 4'd1;
      end
      case (state_q)
        RX_IDLE: begin
          if (!w_sync) begin
            len_d    = Len;
            nstop_d  = NumStop;
            paren_d  = ParEn;
            par_d    = Par;
            tick_d   = 4'd0;
            data_d   = 8'h00;
            pbit_d   = 1'b0;
            fe_acc_d = 1'b0;
            stop2_d  = 1'b0;
            state_d  = RX_START;
          end
        end
        RX_START: begin
          if (w_sample) begin
            if (w_vote) begin
              state_d = RX_IDLE;
            end else begin
              bit_d   = 3'd0;
              state_d = RX_SHIFT;
            end
          end
        end
        RX_SHIFT: begin
          if (w_sample) begin
            data_d[bit_q] = w_vote;
            bit_d         = bit_q + 3'd1;
            if (w_last_bit) begin
              state_d = paren_q ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (w_sample) begin
            pbit_d  = w_vote;
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (brkw_q) begin
            if (w_sync) begin
              brkw_d  = 1'b0;
              state_d = RX_IDLE;
            end
          end else if (w_sample) begin
            if (nstop_q && !stop2_q) begin
              stop2_d  = 1'b1;
              fe_acc_d = ~w_vote;
            end else begin
              rf_we  = 1'b1;
              rhr_d  = w_brk_now ? 8'h00 : data_q;
              pe_d   = paren_q && (pbit_q != par_bit(data_q, par_q));
              fe_d   = w_fe_now;
              brk_d  = w_brk_now;
              brkw_d = w_brk_now;
              if (!w_brk_now) begin
                state_d = RX_IDLE;
              end
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // All receiver state, format latches and held status
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= RX_IDLE;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      stop2_q  <= 1'b0;
      brkw_q   <= 1'b0;
      data_q   <= 8'h00;
      pbit_q   <= 1'b0;
      fe_acc_q <= 1'b0;
      len_q    <= 1'b0;
      nstop_q  <= 1'b0;
      paren_q  <= 1'b0;
      par_q    <= pPar_Odd;
      rhr_q    <= 8'h00;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      stop2_q  <= stop2_d;
      brkw_q   <= brkw_d;
      data_q   <= data_d;
      pbit_q   <= pbit_d;
      fe_acc_q <= fe_acc_d;
      len_q    <= len_d;
      nstop_q  <= nstop_d;
      paren_q  <= paren_d;
      par_q    <= par_d;
      rhr_q    <= rhr_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
    end
  end

  // Character and status are presented in the same cycle as the strobe so
  // the FIFO captures them on RF_WE; they are held in registers afterwards.
  assign RF_WE    = rf_we;
  assign RHR      = rhr_d;
  assign PE       = pe_d;
  assign FE       = fe_d;
  assign Brk      = brk_d;
  assign RxIdle   = (state_q == RX_IDLE);
  assign RxStart  = (state_q == RX_START);
  assign RxShift  = (state_q == RX_SHIFT);
  assign RxParity = (state_q == RX_PARITY);
  assign RxStop   = (state_q == RX_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rxsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_rxsm                                               |
// | Purpose : Self-checking bench for uart_rxsm. A behavioural serial    |
// |           transmitter drives RxD; expected characters and status     |
// |           come from a frame-level model.                             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_uart_rxsm;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] rhr;
    logic       pe;
    logic       fe;
    logic       brk;
  } ev_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       CE_16x = 1'b1;
  logic       Len = 1'b0;
  logic       NumStop = 1'b0;
  logic       ParEn = 1'b0;
  logic [1:0] Par = 2'd0;
  logic       RxD = 1'b1;
  logic [7:0] RHR;
  logic       RF_WE, PE, FE, Brk;
  logic       RxIdle, RxStart, RxShift, RxParity, RxStop;

  int checks = 0;
  int failures = 0;
  int ce_div = 1;
  int ce_cnt = 0;
  int ce_viol = 0;
  int start_cnt = 0;
  int ev_wr = 0;
  bit scramble = 1'b0;
  ev_t ev_mem [256];
  logic tx_bits [$];

  uart_rxsm #(.pSampleTick(4'd8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .CE_16x   (CE_16x),
    .Len      (Len),
    .NumStop  (NumStop),
    .ParEn    (ParEn),
    .Par      (Par),
    .RxD      (RxD),
    .RHR      (RHR),
    .RF_WE    (RF_WE),
    .PE       (PE),
    .FE       (FE),
    .Brk      (Brk),
    .RxIdle   (RxIdle),
    .RxStart  (RxStart),
    .RxShift  (RxShift),
    .RxParity (RxParity),
    .RxStop   (RxStop)
  );

  always #5 Clk = ~Clk;

  // 16x enable: one pulse every ce_div clocks
  always @(posedge Clk) begin
    #1;
    if (ce_cnt >= ce_div - 1) begin
      ce_cnt = 0;
      CE_16x = 1'b1;
    end else begin
      ce_cnt = ce_cnt + 1;
      CE_16x = 1'b0;
    end
  end

  // Record every FIFO write and watch for strobes outside a 16x tick
  always @(negedge Clk) begin
    if (RF_WE === 1'b1) begin
      ev_mem[ev_wr % 256] = {RHR, PE, FE, Brk};
      ev_wr = ev_wr + 1;
      if (CE_16x !== 1'b1) ce_viol = ce_viol + 1;
    end
    if (RxStart === 1'b1) start_cnt = start_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic rand_fmt();
    Len     = 1'($urandom_range(0, 1));
    NumStop = 1'($urandom_range(0, 1));
    ParEn   = 1'($urandom_range(0, 1));
    Par     = 2'($urandom_range(0, 3));
  endtask

  function automatic string fmt_ev(input ev_t e);
    return $sformatf("rhr=%h pe=%b fe=%b brk=%b", e.rhr, e.pe, e.fe, e.brk);
  endfunction

  // Frame model: builds the line bit sequence for the current format and
  // the character/status a correct receiver must report for it.
  task automatic build_frame(input logic [7:0] d, input bit bad_par, input bit stop0, output ev_t exp);
    logic [7:0] m;
    logic       good_p, p;
    int         nb;
    nb = Len ? 7 : 8;
    m  = d;
    if (Len) m[7] = 1'b0;
    case (Par)
      pPar_Odd:  good_p = ($countones(m) % 2 == 0);
      pPar_Even: good_p = ($countones(m) % 2 == 1);
      pPar_Mark: good_p = 1'b1;
      default:   good_p = 1'b0;
    endcase
    p = bad_par ? ~good_p : good_p;
    tx_bits.delete();
    tx_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) tx_bits.push_back(m[i]);
    if (ParEn) tx_bits.push_back(p);
    tx_bits.push_back(stop0 ? 1'b0 : 1'b1);
    if (NumStop) tx_bits.push_back(1'b1);
    exp.brk = stop0 && (m == 8'h00) && (!ParEn || !p);
    exp.rhr = exp.brk ? 8'h00 : m;
    exp.pe  = ParEn && bad_par;
    exp.fe  = stop0;
  endtask

  // Drive tx_bits onto RxD, 16 ticks per bit. Optional one-cycle glitch at
  // (gbit,gcyc) and optional reset pulse at (rbit,rcyc) that aborts the frame.
  task automatic send(input int gbit, input int gcyc, input int rbit, input int rcyc);
    int per;
    per = 16 * ce_div;
    for (int b = 0; b < tx_bits.size(); b++) begin
      for (int c = 0; c < per; c++) begin
        if (b == rbit && c == rcyc) begin
          Rst = 1'b1;
          RxD = 1'b1;
          cyc(1);
          Rst = 1'b0;
          return;
        end
        if (scramble && b == 2 && c == 0) rand_fmt();
        RxD = (b == gbit && c == gcyc) ? ~tx_bits[b] : tx_bits[b];
        cyc(1);
      end
    end
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    RxD = 1'b1;
    cyc(4);
    Rst = 1'b0;
    cyc(3);
    checks++; if (RHR !== 8'h00) begin failures++; $display("FAIL reset_rhr got=%h exp=00", RHR); end
    checks++; if (RF_WE !== 1'b0) begin failures++; $display("FAIL reset_rfwe got=%b exp=0", RF_WE); end
    checks++; if ({PE, FE, Brk} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {PE, FE, Brk}); end
    checks++; if ({RxIdle, RxStart, RxShift, RxParity, RxStop} !== 5'b10000) begin
      failures++; $display("FAIL reset_flags got=%b exp=10000", {RxIdle, RxStart, RxShift, RxParity, RxStop});
    end
  endtask

  task automatic test_8n1();
    logic [7:0] bytes [8];
    ev_t e;
    int  w0;
    bytes[0] = 8'hFF; bytes[1] = 8'h80; bytes[2] = 8'h7B; bytes[3] = 8'h00;
    for (int i = 4; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = pPar_Odd;
    for (int i = 0; i < 8; i++) begin
      build_frame(bytes[i], 1'b0, 1'b0, e);
      w0 = ev_wr;
      send(-1, 0, -1, 0);
      cyc(32);
      checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL 8n1_count byte=%h got=%0d exp=1", bytes[i], ev_wr - w0); end
      checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL 8n1_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [8];
    bit  bad [8];
    ev_t e;
    int  w0;
    bytes[0] = 8'h41; bad[0] = 1'b0;
    bytes[1] = 8'h5A; bad[1] = 1'b1;
    for (int i = 2; i < 8; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      bad[i]   = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 2) begin
        Len = 1'b1; NumStop = 1'b1; ParEn = 1'b1; Par = pPar_Even;
      end else begin
        rand_fmt();
        ParEn = 1'b1;
      end
      build_frame(bytes[i], bad[i], 1'b0, e);
      w0 = ev_wr;
      send(-1, 0, -1, 0);
      cyc(32);
      checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL par_count byte=%h got=%0d exp=1", bytes[i], ev_wr - w0); end
      checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL par_char len=%b par=%0d got %s exp %s", Len, Par, fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
    end
  endtask

  task automatic test_framing();
    ev_t e;
    int  w0;
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = pPar_Odd;
    build_frame(8'h61, 1'b0, 1'b1, e);
    w0 = ev_wr;
    send(-1, 0, -1, 0);
    cyc(48);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL fe_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
    build_frame(8'h31, 1'b0, 1'b0, e);
    w0 = ev_wr;
    send(-1, 0, -1, 0);
    cyc(32);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL fe_next_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL fe_next_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
  endtask

  task automatic test_break();
    ev_t e;
    ev_t bexp;
    int  w0;
    bexp = '{rhr: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1};
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = pPar_Odd;
    w0 = ev_wr;
    RxD = 1'b0;
    cyc(15 * 16);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL brk_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (RxStop !== 1'b1) begin failures++; $display("FAIL brk_wait_stop got=%b exp=1", RxStop); end
    cyc(5 * 16);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL brk_hold_count got=%0d exp=1", ev_wr - w0); end
    RxD = 1'b1;
    cyc(40);
    checks++; if (RxIdle !== 1'b1) begin failures++; $display("FAIL brk_release_idle got=%b exp=1", RxIdle); end
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL brk_release_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== bexp) begin failures++; $display("FAIL brk_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(bexp)); end
    build_frame(8'h39, 1'b0, 1'b0, e);
    w0 = ev_wr;
    send(-1, 0, -1, 0);
    cyc(32);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL brk_next_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL brk_next_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
  endtask

  task automatic test_glitch();
    ev_t e;
    int  w0, s0;
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = pPar_Odd;
    w0 = ev_wr;
    s0 = start_cnt;
    RxD = 1'b0;
    cyc(6);
    RxD = 1'b1;
    cyc(40);
    checks++; if (start_cnt == s0) begin failures++; $display("FAIL glitch_start got=%0d exp>0", start_cnt - s0); end
    checks++; if (RxIdle !== 1'b1) begin failures++; $display("FAIL glitch_idle got=%b exp=1", RxIdle); end
    checks++; if (ev_wr != w0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", ev_wr - w0); end
    // Data bit 3 is line bit 4; one wrong sample in the middle of its window
    build_frame(8'h7A, 1'b0, 1'b0, e);
    w0 = ev_wr;
    send(4, 9, -1, 0);
    cyc(32);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL vote_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL vote_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    int  w0;
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = pPar_Odd;
    build_frame(8'h60, 1'b0, 1'b0, e);
    w0 = ev_wr;
    send(-1, 0, 5, 4);
    checks++; if ({RxIdle, RxStart, RxShift, RxParity, RxStop} !== 5'b10000) begin
      failures++; $display("FAIL rstmid_flags got=%b exp=10000", {RxIdle, RxStart, RxShift, RxParity, RxStop});
    end
    checks++; if ({RHR, PE, FE, Brk} !== 11'd0) begin failures++; $display("FAIL rstmid_status got rhr=%h pe=%b fe=%b brk=%b exp zero", RHR, PE, FE, Brk); end
    cyc(48);
    checks++; if (ev_wr != w0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", ev_wr - w0); end
    build_frame(8'h5B, 1'b0, 1'b0, e);
    w0 = ev_wr;
    send(-1, 0, -1, 0);
    cyc(32);
    checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", ev_wr - w0); end
    checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL rstmid_next_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
  endtask

  task automatic test_ce_gated();
    ev_t e;
    int  w0;
    logic [7:0] d;
    ce_div = 3;
    cyc(6);
    Len = 1'b0; NumStop = 1'b1; ParEn = 1'b1; Par = pPar_Odd;
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom_range(0, 255));
      build_frame(d, 1'b0, 1'b0, e);
      w0 = ev_wr;
      send(-1, 0, -1, 0);
      cyc(32 * ce_div);
      checks++; if (ev_wr - w0 != 1) begin failures++; $display("FAIL ce_count byte=%h got=%0d exp=1", d, ev_wr - w0); end
      checks++; if (ev_mem[w0 % 256] !== e) begin failures++; $display("FAIL ce_char got %s exp %s", fmt_ev(ev_mem[w0 % 256]), fmt_ev(e)); end
    end
    checks++; if (ce_viol != 0) begin failures++; $display("FAIL ce_strobe_outside_tick got=%0d exp=0", ce_viol); end
    ce_div = 1;
    cyc(6);
  endtask

  task automatic test_back_to_back();
    ev_t exp_ev [10];
    ev_t e;
    int  w0;
    w0 = ev_wr;
    scramble = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_fmt();
      build_frame(8'($urandom_range(0, 255)), ParEn && ($urandom_range(0, 3) == 0), 1'b0, e);
      exp_ev[i] = e;
      send(-1, 0, -1, 0);
    end
    scramble = 1'b0;
    cyc(32);
    checks++; if (ev_wr - w0 != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", ev_wr - w0); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (ev_mem[(w0 + i) % 256] !== exp_ev[i]) begin
        failures++; $display("FAIL b2b_char idx=%0d got %s exp %s", i, fmt_ev(ev_mem[(w0 + i) % 256]), fmt_ev(exp_ev[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_break();
    test_glitch();
    test_reset_mid();
    test_ce_gated();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rxsm.md
Name: uart_rxsm

Overview:
- Asynchronous serial receive state machine; direct downstream consumer of the UART_TXSM serial stream.
- Samples RxD at 16x the baud rate, frames start/data/parity/stop, and checks parity and framing.
- Writes each received character plus status into the receive FIFO through a one-cycle write strobe.
- Mirrors UART_TXSM's format controls (Len, NumStop, ParEn, Par) so a TX/RX pair configures identically.

Parameters:
- pSampleTick, 4'd8: 16x tick index within a bit used as the centre sample; the majority vote uses ticks pSampleTick-1, pSampleTick, pSampleTick+1.

Ports:
- Clk  input  1  UART clock; single clock domain.
- Rst  input  1  synchronous, active-high reset.
- CE_16x  input  1  16x baud-rate clock enable. All state advances only when CE_16x=1.
- Len  input  1  0 = 8 data bits; 1 = 7 data bits.
- NumStop  input  1  0 = 1 stop bit; 1 = 2 stop bits.
- ParEn  input  1  parity bit present.
- Par  input  2  0 odd, 1 even, 2 space (0), 3 mark (1).
- RxD  input  1  serial data in, LSB first, start bit = 0. Asynchronous to Clk.
- RHR  output  8  received character; bit 7 = 0 when Len=1.
- RF_WE  output  1  receive FIFO write strobe, one Clk wide.
- PE  output  1  parity error for the character in RHR.
- FE  output  1  framing error for the character in RHR.
- Brk  output  1  break detected.
- RxIdle, RxStart, RxShift, RxParity, RxStop  output  1 each  one-hot state flags.

Behaviour:
- Reset:
  - RHR=0, RF_WE=0, PE=0, FE=0, Brk=0, RxIdle=1, all other state flags 0.
  - Synchronizer flops preset to 1; tick counter and bit counter cleared.
- Input conditioning:
  - RxD passes through a 2-flop synchronizer.
  - The majority of 3 samples (ticks pSampleTick-1..+1) gives the bit value.
- Idle:
  - On a CE_16x cycle with synchronized RxD=0, latch Len, NumStop, ParEn and Par.
  - Clear the tick counter and go to Start.
  - Format inputs that change mid-frame have no effect until the next start.
- Start:
  - At tick pSampleTick+1, evaluate the vote.
  - Vote 1 (glitch): return to Idle; no RF_WE.
  - Vote 0: go to Shift with bit count 0.
  - The tick counter wraps every 16 CE_16x.
- Shift:
  - Each bit's voted value shifts in LSB first.
  - After 8 bits (7 if Len), go to Parity if ParEn, else Stop.
- Parity:
  - Expected bit: odd → XOR(data) inverted; even → XOR(data); space → 0; mark → 1.
  - PE_next = received bit ≠ expected.
- Stop:
  - Vote each stop bit; FE_next=1 if any stop bit votes 0.
  - With NumStop=1, both stop bits are checked.
  - At the vote of the last stop bit: RHR, PE and FE update and RF_WE=1 for exactly one Clk. These outputs hold until the next RF_WE.
  - Latency: RF_WE at tick pSampleTick+1 of the last stop bit; no half-bit wait.
- Break:
  - Condition: FE_next=1 and all data bits 0 and (no parity or parity bit 0).
  - Response: RHR=0x00, FE=1, Brk=1 with RF_WE.
  - The state machine then waits in Stop until synchronized RxD=1 on a CE_16x cycle, then goes to Idle. Brk clears at the next RF_WE.
- Non-break stop: return to Idle at the same cycle as RF_WE.
- A new start edge is accepted from the first CE_16x cycle after returning to Idle.
- The receiver ignores FIFO full; overrun is handled by the FIFO.
- Rst asserted mid-frame: back to Idle next Clk, no RF_WE, status cleared.
- CE_16x=0: all state holds; RF_WE is never asserted on a cycle with CE_16x=0.

Decomposition:
- Shared package uart_pkg:
  - Par encodings: pPar_Odd=0, pPar_Even=1, pPar_Space=2, pPar_Mark=3.
  - One-hot state constants: pIdle, pStart, pShift, pParity, pStop.
  - Ticks-per-bit constant 16, shared with UART_TXSM.
- Sub-module uart_rxd_vote: 2-flop synchronizer plus a 3-sample shift register and majority output. Inputs Clk, Rst, CE_16x, RxD; output RxD_Vote.

Test Plan:
- Loopback from a UART_TXSM instance, CE_16x=1, 8N1, bytes 0xFF, 0x80, 0x7B, 0x00 → four RF_WE pulses with RHR matching each byte, PE=FE=Brk=0.
- 7E2, Par=1: send 0x41 → RHR=0x41, PE=0. Then force the parity bit inverted for 0x5A → RHR=0x5A, PE=1.
- 8N1 with the stop bit forced to 0 for 0x61 → RF_WE, RHR=0x61, FE=1, Brk=0; the next frame 0x31 decodes cleanly with FE=0.
- RxD held low for 20 bit times → one RF_WE with RHR=0x00, FE=1, Brk=1. No second RF_WE until RxD returns high. The next byte 0x39 is received correctly with Brk=0.
- Low glitch of 6 Clk on idle RxD → state returns to RxIdle, no RF_WE. One-cycle glitch mid data bit 3 of 0x7A → majority vote still yields RHR=0x7A.
- Rst pulsed during data bit 4 of 0x60 → no RF_WE, RxIdle=1 next cycle. The next frame 0x5B is received correctly.
